// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI mode-0 byte shifter: FSM state encoding,
// transfer length in ce ticks and the idle level of the data-out line.
package spi_shift_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One byte = 8 bits x 2 half periods.
  localparam int   SPI_TICKS     = 16;
  localparam logic SPI_IDLE_MOSI = 1'b1;
  localparam int   TICK_W        = 5;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 byte shifter. Accepts a tx or rx strobe while idle, serialises
// one byte MSB first on ck/mosi (one ce tick per half bit period), samples
// miso on each falling ck edge and keeps the last QW bits received during rx
// transfers. busy covers the transfer; done pulses for one clock at the end.
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int QW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          tx,
  input  logic          rx,
  input  logic [7:0]    d,
  output logic [QW-1:0] q,
  output logic          busy,
  output logic          done,
  output logic          ck,
  output logic          mosi,
  input  logic          miso
);

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [TICK_W-1:0]   tick_inc;
  logic [7:0]          sr_q, sr_d;
  logic                rxm_q, rxm_d;
  logic [QW-1:0]       q_q, q_d;
  logic                ck_q, ck_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;
  logic                last_tick;
  logic                sr_msb_unused;

  // The outgoing bit is always taken from sr[6] before the shift, so the
  // top bit of sr is never read back after the load.
  assign sr_msb_unused = sr_q[7];

  assign tick_inc  = tick_q + 1'b1;
  // A request is only honoured from IDLE; busy/DONE requests are dropped.
  assign accept    = (state_q == ST_IDLE) && (tx || rx);
  assign last_tick = (state_q == ST_SHIFT) && ce && (tick_inc == TICK_W'(SPI_TICKS));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: SHIFT leaves on the 16th ce tick, DONE lasts one clock.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)    state_d = ST_SHIFT;
      ST_SHIFT: if (last_tick) state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: load on accept, then ck toggles on every
  // ce tick; falling edges sample miso and present the next mosi bit.
  always_comb begin
    tick_d = tick_q;
    sr_d   = sr_q;
    rxm_d  = rxm_q;
    q_d    = q_q;
    ck_d   = ck_q;
    mosi_d = mosi_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // tx has priority; a simultaneous rx is discarded.
          sr_d   = tx ? d : 8'hFF;
          rxm_d  = !tx;
          mosi_d = tx ? d[7] : SPI_IDLE_MOSI;
          busy_d = 1'b1;
          tick_d = '0;
        end
      end
      ST_SHIFT: begin
        if (ce) begin
          tick_d = tick_inc;
          if (tick_inc[0]) begin
            ck_d = 1'b1;
          end else begin
            ck_d = 1'b0;
            sr_d = {sr_q[6:0], miso};
            if (rxm_q) q_d = {q_q[QW-2:0], miso};
            if (last_tick) begin
              mosi_d = SPI_IDLE_MOSI;
              busy_d = 1'b0;
              done_d = 1'b1;
            end else begin
              mosi_d = sr_q[6];
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath/output registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_q <= '0;
      sr_q   <= '0;
      rxm_q  <= 1'b0;
      q_q    <= '0;
      ck_q   <= 1'b0;
      mosi_q <= SPI_IDLE_MOSI;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
      sr_q   <= sr_d;
      rxm_q  <= rxm_d;
      q_q    <= q_d;
      ck_q   <= ck_d;
      mosi_q <= mosi_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign q    = q_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ck   = ck_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: transaction-level reference model checked every
// cycle, a mosi byte monitor, and directed scenarios with literal expectations.
module tb_spi_shift_engine;
  localparam int QW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ce    = 1'b0;
  logic          tx    = 1'b0;
  logic          rx    = 1'b0;
  logic [7:0]    d     = 8'h00;
  logic          miso  = 1'b0;
  logic [QW-1:0] q;
  logic          busy, done, ck, mosi;

  always #5 clock = ~clock;

  spi_shift_engine #(.QW(QW)) dut (
    .clock(clock), .reset(reset), .ce(ce), .tx(tx), .rx(rx), .d(d),
    .q(q), .busy(busy), .done(done), .ck(ck), .mosi(mosi), .miso(miso)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ce_mode = 0;  // 0 off, 1 every second clock, 2 always
  bit cmp_en = 1'b0;
  logic [7:0] resp = 8'h00;  // byte the flash returns on the next rx

  // Reference model: a transfer is "n half-periods elapsed" of a byte.
  int            m_st = 0;  // 0 idle, 1 transferring, 2 done pulse
  int            m_n = 0;
  logic [7:0]    m_byte = 8'hFF;
  bit            m_rx = 1'b0;
  logic [QW-1:0] m_q = '0;

  always @(posedge clock) begin
    if (reset) begin
      m_st = 0; m_n = 0; m_q = '0;
    end else if (m_st == 0) begin
      if (tx || rx) begin
        m_byte = tx ? d : 8'hFF;
        m_rx   = !tx;
        m_n    = 0;
        m_st   = 1;
      end
    end else if (m_st == 1) begin
      if (ce) begin
        m_n = m_n + 1;
        if (m_n % 2 == 0 && m_rx) m_q = QW'((m_q << 1) | QW'(miso));
        if (m_n == 16) m_st = 2;
      end
    end else begin
      m_st = 0;
    end
  end

  // Flash side: present bit k of resp while ck is high for bit k.
  always @(negedge clock) begin
    if (m_st == 1 && m_rx && m_n < 16) miso = resp[7 - m_n / 2];
    else                               miso = 1'b0;
  end

  // Monitor: collect the mosi bit at each ck rise; one byte per done pulse.
  logic       ck_prev = 1'b0;
  logic [7:0] mon_sr = 8'h00;
  int         mon_bits = 0;
  int         dn_cnt = 0;
  logic [7:0] cap_q[$];
  int         capb_q[$];

  always @(negedge clock) begin
    if (reset) begin
      mon_bits = 0;
      ck_prev  = 1'b0;
    end else begin
      if (ck === 1'b1 && ck_prev === 1'b0) begin
        mon_sr   = {mon_sr[6:0], mosi};
        mon_bits = mon_bits + 1;
      end
      ck_prev = ck;
      if (done === 1'b1) begin
        dn_cnt = dn_cnt + 1;
        cap_q.push_back(mon_sr);
        capb_q.push_back(mon_bits);
        mon_bits = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance one clock, update ce, and compare every output with the model.
  task automatic step();
    int  idx;
    logic e_mosi;
    @(negedge clock);
    cyc++;
    ce = (ce_mode == 2) ? 1'b1 : (ce_mode == 1) ? cyc[0] : 1'b0;
    if (cmp_en) begin
      idx    = 7 - m_n / 2;
      e_mosi = (m_st == 1) ? m_byte[idx[2:0]] : 1'b1;
      chk("mdl_q",    32'(q),    32'(m_q));
      chk("mdl_busy", 32'(busy), 32'(m_st == 1));
      chk("mdl_done", 32'(done), 32'(m_st == 2));
      chk("mdl_ck",   32'(ck),   32'(m_st == 1 && m_n % 2 == 1));
      chk("mdl_mosi", 32'(mosi), 32'(e_mosi));
    end
  endtask

  task automatic issue(input logic t, input logic r, input logic [7:0] dv);
    step();
    tx = t; rx = r; d = dv;
    step();
    tx = 1'b0; rx = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget, output int bcnt);
    int n;
    n = 0; bcnt = 0;
    while (done !== 1'b1 && n < budget) begin
      if (busy === 1'b1) bcnt++;
      step();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done timeout got %0b want 1 after %0d cycles", nm, done, n);
    end
  endtask

  task automatic wait_tick(input string nm, input int target);
    int n;
    n = 0;
    while (m_n != target && n < 60) begin step(); n++; end
    checks++;
    if (m_n != target) begin
      errors++;
      $display("FAIL %s tick wait got %0d want %0d", nm, m_n, target);
    end
  endtask

  int rd_idx = 0;
  task automatic expect_cap(input string nm, input logic [7:0] exp);
    checks++;
    if (cap_q.size() <= rd_idx) begin
      errors++;
      $display("FAIL %s no byte captured got %0d want %0d bytes", nm, cap_q.size(), rd_idx + 1);
    end else begin
      checks--;
      chk({nm, "_byte"}, 32'(cap_q[rd_idx]), 32'(exp));
      chk({nm, "_ck_pulses"}, 32'(capb_q[rd_idx]), 32'd8);
      rd_idx++;
    end
  endtask

  initial begin
    int b, d0;
    repeat (2) step();
    cmp_en = 1'b1;
    step();
    chk("rst_q", 32'(q), 0);
    chk("rst_ck", 32'(ck), 0);
    chk("rst_mosi", 32'(mosi), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    ce_mode = 1;
    step();

    // 1: tx 03, d changed after accept; 32 busy clocks with this ce phase
    if (cyc[0]) step();
    d0 = dn_cnt;
    issue(1'b1, 1'b0, 8'h03);
    d = 8'hFF;
    wait_done("t1", 100, b);
    chk("t1_busy_cycles", 32'(b), 32'd32);
    repeat (2) step();
    expect_cap("t1", 8'h03);
    chk("t1_q", 32'(q), 0);
    chk("t1_done_pulses", 32'(dn_cnt - d0), 1);

    // 2: rx, flash returns 4D
    resp = 8'h4D;
    issue(1'b0, 1'b1, 8'h00);
    wait_done("t2", 100, b);
    step();
    expect_cap("t2", 8'hFF);
    chk("t2_q", 32'(q), 32'h4D);
    chk("t2_ck_low", 32'(ck), 0);

    // 3: READ 00 70 then rx, each issued right after done
    resp = 8'hC6;
    d0 = dn_cnt;
    issue(1'b1, 1'b0, 8'h03); wait_done("t3a", 100, b);
    issue(1'b1, 1'b0, 8'h00); wait_done("t3b", 100, b);
    issue(1'b1, 1'b0, 8'h70); wait_done("t3c", 100, b);
    issue(1'b0, 1'b1, 8'h00); wait_done("t3d", 100, b);
    step();
    expect_cap("t3_cmd", 8'h03);
    expect_cap("t3_ahi", 8'h00);
    expect_cap("t3_alo", 8'h70);
    expect_cap("t3_rd", 8'hFF);
    chk("t3_q", 32'(q), 32'hC6);
    chk("t3_done_pulses", 32'(dn_cnt - d0), 4);

    // 4: tx AA at tick 5 is ignored
    d0 = dn_cnt;
    issue(1'b1, 1'b0, 8'h3C);
    wait_tick("t4", 5);
    tx = 1'b1; d = 8'hAA;
    step();
    tx = 1'b0;
    wait_done("t4", 100, b);
    repeat (4) step();
    expect_cap("t4", 8'h3C);
    chk("t4_done_pulses", 32'(dn_cnt - d0), 1);
    chk("t4_idle_after", 32'(busy), 0);

    // 5: tx and rx together: tx of 81 wins, q untouched
    issue(1'b1, 1'b1, 8'h81);
    wait_done("t5", 100, b);
    step();
    expect_cap("t5", 8'h81);
    chk("t5_q", 32'(q), 32'hC6);

    // 6: reset at tick 9 of rx, then a fresh tx with a ce freeze inside
    resp = 8'h5A;
    d0 = dn_cnt;
    issue(1'b0, 1'b1, 8'h00);
    wait_tick("t6", 9);
    reset = 1'b1;
    step();
    chk("t6_ck", 32'(ck), 0);
    chk("t6_mosi", 32'(mosi), 1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_q", 32'(q), 0);
    chk("t6_done", 32'(done), 0);
    step();
    reset = 1'b0;
    step();
    chk("t6_no_done", 32'(dn_cnt - d0), 0);
    issue(1'b1, 1'b0, 8'hE7);
    wait_tick("t6_frz", 7);
    ce_mode = 0; ce = 1'b0;
    repeat (10) step();
    chk("frz_ck", 32'(ck), 1);
    chk("frz_mosi", 32'(mosi), 0);
    chk("frz_busy", 32'(busy), 1);
    ce_mode = 1;
    wait_done("t6_fresh", 100, b);
    step();
    expect_cap("t6_fresh", 8'hE7);
    chk("t6_fresh_done", 32'(dn_cnt - d0), 1);
    chk("t6_fresh_q", 32'(q), 0);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
